// File: rtl/wishbone_gpio_port_pkg.sv
// Shared constants for the Wishbone GPIO port: register map, bus width and
// input synchroniser depth.
package wishbone_gpio_port_pkg;

  localparam int unsigned DATA_WIDTH  = 16;
  localparam int unsigned SYNC_STAGES = 2;

  localparam logic [2:0] ADDR_IN      = 3'd0;
  localparam logic [2:0] ADDR_OUT     = 3'd1;
  localparam logic [2:0] ADDR_DIR     = 3'd2;
  localparam logic [2:0] ADDR_EDGE    = 3'd3;
  localparam logic [2:0] ADDR_RISE_EN = 3'd4;
  localparam logic [2:0] ADDR_FALL_EN = 3'd5;
  localparam logic [2:0] ADDR_IRQ_EN  = 3'd6;

endpackage

// File: rtl/gpio_edge_capture.sv
// Pin synchroniser plus rising/falling edge capture into a write-1-to-clear
// EDGE register; edges are suppressed until the pipeline has primed after reset.
module gpio_edge_capture
  import wishbone_gpio_port_pkg::*;
#(
  parameter int unsigned Width = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [Width-1:0] gpio_in_i,
  input  logic [Width-1:0] rise_en_i,
  input  logic [Width-1:0] fall_en_i,
  input  logic [Width-1:0] clear_mask_i,
  output logic [Width-1:0] in_o,
  output logic [Width-1:0] edge_o
);

  logic [SYNC_STAGES-1:0][Width-1:0] sync_q, sync_d;
  logic [Width-1:0] prev_q, prev_d;
  logic [Width-1:0] edge_q, edge_d;
  logic [1:0]       prime_q, prime_d;
  logic [Width-1:0] rise, fall;
  logic             primed;

  always_comb begin
    sync_d    = '0;
    sync_d[0] = gpio_in_i;
    for (int i = 1; i < SYNC_STAGES; i++) begin
      sync_d[i] = sync_q[i-1];
    end
    prev_d = sync_q[SYNC_STAGES-1];

    // Reset zeros in the pipeline must not look like rising edges.
    primed  = (prime_q == 2'd3);
    prime_d = primed ? prime_q : prime_q + 2'd1;

    rise = primed ? (sync_q[SYNC_STAGES-1] & ~prev_q & rise_en_i) : '0;
    fall = primed ? (~sync_q[SYNC_STAGES-1] & prev_q & fall_en_i) : '0;

    // A new edge beats a simultaneous clear on the same bit.
    edge_d = (edge_q & ~clear_mask_i) | rise | fall;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q  <= '0;
      prev_q  <= '0;
      edge_q  <= '0;
      prime_q <= 2'd0;
    end else begin
      sync_q  <= sync_d;
      prev_q  <= prev_d;
      edge_q  <= edge_d;
      prime_q <= prime_d;
    end
  end

  assign in_o   = sync_q[SYNC_STAGES-1];
  assign edge_o = edge_q;

endmodule

// File: rtl/wishbone_gpio_port.sv
// Wishbone slave GPIO port: input sampling, output latch, direction control and
// edge-capture interrupt, with one registered wait state per access.
module wishbone_gpio_port
  import wishbone_gpio_port_pkg::*;
#(
  parameter int unsigned     WIDTH         = 8,
  parameter int unsigned     ADDRESS_WIDTH = 3,
  parameter logic [WIDTH-1:0] OUT_RESET    = '0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [ADDRESS_WIDTH-1:0] wbAdrI,
  input  logic [DATA_WIDTH-1:0]    wbDatI,
  output logic [DATA_WIDTH-1:0]    wbDatO,
  input  logic                     wbStbI,
  input  logic                     wbCycI,
  input  logic                     wbWeI,
  output logic                     wbAckO,
  input  logic [WIDTH-1:0]         gpioIn,
  output logic [WIDTH-1:0]         gpioOut,
  output logic [WIDTH-1:0]         gpioOe,
  output logic                     irq
);

  logic                  req, access, wr;
  logic [2:0]            adr;
  logic [WIDTH-1:0]      wdata, in_val, edge_val, clear_mask;
  logic [DATA_WIDTH-1:0] rdata;

  logic                  ack_q, ack_d;
  logic [DATA_WIDTH-1:0] dat_q, dat_d;
  logic [WIDTH-1:0]      out_q, out_d;
  logic [WIDTH-1:0]      dir_q, dir_d;
  logic [WIDTH-1:0]      rise_en_q, rise_en_d;
  logic [WIDTH-1:0]      fall_en_q, fall_en_d;
  logic [WIDTH-1:0]      irq_en_q, irq_en_d;

  // Upper address bits and data bits above WIDTH are intentionally ignored.
  logic unused_bus;
  assign unused_bus = ^{wbAdrI, wbDatI};

  assign adr   = wbAdrI[2:0];
  assign wdata = wbDatI[WIDTH-1:0];

  always_comb begin
    req    = wbStbI & wbCycI;
    access = req & ~ack_q;
    wr     = access & wbWeI;
    ack_d  = access;

    rdata = '0;
    case (adr)
      ADDR_IN:      rdata[WIDTH-1:0] = in_val;
      ADDR_OUT:     rdata[WIDTH-1:0] = out_q;
      ADDR_DIR:     rdata[WIDTH-1:0] = dir_q;
      ADDR_EDGE:    rdata[WIDTH-1:0] = edge_val;
      ADDR_RISE_EN: rdata[WIDTH-1:0] = rise_en_q;
      ADDR_FALL_EN: rdata[WIDTH-1:0] = fall_en_q;
      ADDR_IRQ_EN:  rdata[WIDTH-1:0] = irq_en_q;
      default:      rdata = '0;
    endcase
    dat_d = access ? rdata : dat_q;

    out_d      = (wr && adr == ADDR_OUT)     ? wdata : out_q;
    dir_d      = (wr && adr == ADDR_DIR)     ? wdata : dir_q;
    rise_en_d  = (wr && adr == ADDR_RISE_EN) ? wdata : rise_en_q;
    fall_en_d  = (wr && adr == ADDR_FALL_EN) ? wdata : fall_en_q;
    irq_en_d   = (wr && adr == ADDR_IRQ_EN)  ? wdata : irq_en_q;
    clear_mask = (wr && adr == ADDR_EDGE)    ? wdata : '0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ack_q     <= 1'b0;
      dat_q     <= '0;
      out_q     <= OUT_RESET;
      dir_q     <= '0;
      rise_en_q <= '0;
      fall_en_q <= '0;
      irq_en_q  <= '0;
    end else begin
      ack_q     <= ack_d;
      dat_q     <= dat_d;
      out_q     <= out_d;
      dir_q     <= dir_d;
      rise_en_q <= rise_en_d;
      fall_en_q <= fall_en_d;
      irq_en_q  <= irq_en_d;
    end
  end

  gpio_edge_capture #(
    .Width (WIDTH)
  ) u_edge_capture (
    .clk_i        (clk),
    .rst_ni       (rst),
    .gpio_in_i    (gpioIn),
    .rise_en_i    (rise_en_q),
    .fall_en_i    (fall_en_q),
    .clear_mask_i (clear_mask),
    .in_o         (in_val),
    .edge_o       (edge_val)
  );

  assign wbAckO  = ack_q;
  assign wbDatO  = dat_q;
  assign gpioOut = out_q;
  assign gpioOe  = dir_q;
  assign irq     = |(edge_val & irq_en_q);

endmodule

// File: tb/tb_wishbone_gpio_port.sv
// Randomised and directed bench for wishbone_gpio_port against a cycle-level
// register-map model that derives IN/EDGE from the pin history.
module tb_wishbone_gpio_port;

  localparam logic [7:0] OutRst = 8'h3C;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [2:0]  adr;
  logic [15:0] dat_i, dat_o;
  logic        stb, cyc, we, ack;
  logic [7:0]  pin, gout, goe;
  logic        irq;

  always #5 clk = ~clk;

  wishbone_gpio_port #(
    .WIDTH         (8),
    .ADDRESS_WIDTH (3),
    .OUT_RESET     (OutRst)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .wbAdrI  (adr),
    .wbDatI  (dat_i),
    .wbDatO  (dat_o),
    .wbStbI  (stb),
    .wbCycI  (cyc),
    .wbWeI   (we),
    .wbAckO  (ack),
    .gpioIn  (pin),
    .gpioOut (gout),
    .gpioOe  (goe),
    .irq     (irq)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state.
  logic [7:0]  m_out, m_dir, m_edge, m_rise_en, m_fall_en, m_irq_en;
  logic        m_ack;
  logic [15:0] m_dat;
  logic [7:0]  hist[$];
  int          edges;

  task automatic check_eq(input string tag, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h", tag, act, exp);
    end
  endtask

  task automatic model_reset();
    m_out = OutRst; m_dir = 8'h00; m_edge = 8'h00;
    m_rise_en = 8'h00; m_fall_en = 8'h00; m_irq_en = 8'h00;
    m_ack = 1'b0; m_dat = 16'h0000;
    hist = {8'h00, 8'h00, 8'h00};
    edges = 0;
  endtask

  // One rising edge: IN shows the pin as sampled two edges earlier, and an
  // edge is judged between samples two and three edges back.
  task automatic model_step();
    logic        acc;
    logic [7:0]  s2, pv, rise, fall, clr, wd;
    logic [15:0] rd;
    int          n;
    hist.push_back(pin);
    n = hist.size();
    edges++;
    s2   = hist[n-3];
    pv   = hist[n-4];
    acc  = stb && cyc && !m_ack;
    wd   = dat_i[7:0];
    rise = (edges >= 4) ? (s2 & ~pv & m_rise_en) : 8'h00;
    fall = (edges >= 4) ? (~s2 & pv & m_fall_en) : 8'h00;
    case (adr)
      3'd0:    rd = {8'h00, s2};
      3'd1:    rd = {8'h00, m_out};
      3'd2:    rd = {8'h00, m_dir};
      3'd3:    rd = {8'h00, m_edge};
      3'd4:    rd = {8'h00, m_rise_en};
      3'd5:    rd = {8'h00, m_fall_en};
      3'd6:    rd = {8'h00, m_irq_en};
      default: rd = 16'h0000;
    endcase
    clr = 8'h00;
    if (acc) begin
      m_dat = rd;
      if (we) begin
        case (adr)
          3'd1:    m_out = wd;
          3'd2:    m_dir = wd;
          3'd3:    clr = wd;
          3'd4:    m_rise_en = wd;
          3'd5:    m_fall_en = wd;
          3'd6:    m_irq_en = wd;
          default: ;
        endcase
      end
    end
    m_edge = (m_edge & ~clr) | rise | fall;
    m_ack  = acc;
    if (hist.size() > 6) void'(hist.pop_front());
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst) model_step();
    #1;
    check_eq("ack", 16'(ack), 16'(m_ack));
    check_eq("dat_o", dat_o, m_dat);
    check_eq("gpio_out", 16'(gout), 16'(m_out));
    check_eq("gpio_oe", 16'(goe), 16'(m_dir));
    check_eq("irq", 16'(irq), 16'(|(m_edge & m_irq_en)));
  endtask

  task automatic bus_req(input logic w, input logic [2:0] a, input logic [15:0] d);
    stb = 1'b1; cyc = 1'b1; we = w; adr = a; dat_i = d;
  endtask

  task automatic bus_idle();
    stb = 1'b0; cyc = 1'b0; we = 1'b0;
  endtask

  task automatic bus_write(input logic [2:0] a, input logic [15:0] d);
    bus_req(1'b1, a, d);
    tick();
    bus_idle();
    tick();
  endtask

  task automatic bus_read(input logic [2:0] a, output logic [15:0] d);
    bus_req(1'b0, a, 16'h0000);
    tick();
    check_eq("rd_ack_latency", 16'(ack), 16'h0001);
    d = dat_o;
    bus_idle();
    tick();
  endtask

  initial begin
    logic [15:0] d;
    bus_idle();
    adr = 3'd0; dat_i = 16'h0000; pin = 8'h00;
    model_reset();

    // Reset state.
    #12;
    check_eq("rst_ack", 16'(ack), 16'h0000);
    check_eq("rst_dat", dat_o, 16'h0000);
    check_eq("rst_gpio_out", 16'(gout), 16'h003C);
    check_eq("rst_gpio_oe", 16'(goe), 16'h0000);
    check_eq("rst_irq", 16'(irq), 16'h0000);
    rst = 1'b1;
    repeat (5) tick();
    bus_read(3'd1, d);
    check_eq("rd_out_reset", d, 16'h003C);

    // Direction register drops upper bus bits.
    bus_write(3'd2, 16'hFF0F);
    bus_read(3'd2, d);
    check_eq("rd_dir", d, 16'h000F);
    check_eq("gpio_oe_dir", 16'(goe), 16'h000F);

    // Held strobe acks on alternate cycles.
    check_eq("held_ack_pre", 16'(ack), 16'h0000);
    bus_req(1'b0, 3'd2, 16'h0000);
    for (int i = 0; i < 4; i++) begin
      tick();
      check_eq("held_ack", 16'(ack), (i % 2 == 0) ? 16'h0001 : 16'h0000);
    end
    bus_idle();
    tick();

    // Rising edge latency and W1C clear.
    bus_write(3'd4, 16'h0001);
    bus_write(3'd6, 16'h0001);
    pin = 8'h01;
    tick();
    tick();
    check_eq("irq_before_k2", 16'(irq), 16'h0000);
    bus_req(1'b0, 3'd0, 16'h0000);
    tick();
    check_eq("rd_in_k2", dat_o, 16'h0001);
    check_eq("irq_at_k2", 16'(irq), 16'h0001);
    bus_idle();
    tick();
    bus_read(3'd3, d);
    check_eq("rd_edge_rise", d, 16'h0001);
    bus_write(3'd3, 16'h0001);
    check_eq("irq_cleared", 16'(irq), 16'h0000);
    bus_read(3'd3, d);
    check_eq("rd_edge_cleared", d, 16'h0000);

    // Pins high through reset release must not register rising edges.
    pin = 8'hFF;
    rst = 1'b0;
    model_reset();
    #2;
    check_eq("rst2_ack", 16'(ack), 16'h0000);
    repeat (2) tick();
    rst = 1'b1;
    bus_write(3'd4, 16'h00FF);
    repeat (6) tick();
    bus_read(3'd3, d);
    check_eq("prime_suppress", d, 16'h0000);
    bus_write(3'd5, 16'h00FF);
    pin = 8'h00;
    repeat (4) tick();
    bus_read(3'd3, d);
    check_eq("fall_all", d, 16'h00FF);

    // Edge set beats a simultaneous W1C clear.
    bus_write(3'd3, 16'h00FF);
    bus_read(3'd3, d);
    check_eq("edge_clear_all", d, 16'h0000);
    pin = 8'h02;
    tick();
    tick();
    bus_req(1'b1, 3'd3, 16'h0002);
    tick();
    bus_idle();
    tick();
    bus_read(3'd3, d);
    check_eq("set_beats_clear", d, 16'h0002);

    // Reset during the ack cycle of an OUT write.
    bus_req(1'b1, 3'd1, 16'h0055);
    tick();
    check_eq("wr_ack", 16'(ack), 16'h0001);
    #2;
    rst = 1'b0;
    model_reset();
    #1;
    check_eq("mid_rst_ack", 16'(ack), 16'h0000);
    check_eq("mid_rst_out", 16'(gout), 16'h003C);
    bus_idle();
    #2;
    rst = 1'b1;
    repeat (3) tick();
    bus_read(3'd1, d);
    check_eq("out_after_rst", d, 16'h003C);

    // Randomised traffic with pin activity and occasional resets.
    for (int i = 0; i < 3000; i++) begin
      stb   = ($urandom_range(0, 3) != 0);
      cyc   = ($urandom_range(0, 7) != 0);
      we    = ($urandom_range(0, 1) != 0);
      adr   = 3'($urandom_range(0, 7));
      dat_i = 16'($urandom);
      if ($urandom_range(0, 3) == 0) pin = 8'($urandom);
      if ($urandom_range(0, 499) == 0) begin
        rst = 1'b0;
        model_reset();
        #1;
        check_eq("rand_rst_ack", 16'(ack), 16'h0000);
        rst = 1'b1;
      end
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/wishbone_gpio_port.md
Name: wishbone_gpio_port

Overview:
- Wishbone slave GPIO block that sits directly downstream of the Modbus-to-Wishbone master; it answers Modbus register reads and writes with physical pin I/O.
- Provides a synchronised input sample, an output latch and per-bit direction control.
- Captures rising and falling edges in a write-1-to-clear register and drives a level interrupt.
- Single clock domain; one registered wait state per access.

Parameters:
- WIDTH, 8, number of GPIO bits (1..16); data bus bits [15:WIDTH] read 0 and are ignored on write.
- ADDRESS_WIDTH, 3, word address width; only wbAdrI[2:0] are decoded.
- OUT_RESET, 0, reset value of the OUT register (WIDTH bits).

Ports:
- clk  input  1  single clock; all state updates on its rising edge.
- rst  input  1  asynchronous, active-low reset (asserted when 0); synchronous deassertion is provided upstream.
- wbAdrI  input  ADDRESS_WIDTH  word address.
- wbDatI  input  16  write data.
- wbDatO  output  16  read data, registered.
- wbStbI  input  1  strobe.
- wbCycI  input  1  cycle.
- wbWeI  input  1  write enable.
- wbAckO  output  1  acknowledge, registered.
- gpioIn  input  WIDTH  asynchronous pin inputs.
- gpioOut  output  WIDTH  output latch value.
- gpioOe  output  WIDTH  per-bit output enable; 1 = drive.
- irq  output  1  level interrupt.

Behaviour:
- Register map (word address):
  - 0 IN (RO) = sync2.
  - 1 OUT (RW).
  - 2 DIR (RW).
  - 3 EDGE (R, W1C).
  - 4 RISE_EN (RW).
  - 5 FALL_EN (RW).
  - 6 IRQ_EN (RW).
  - 7 reserved: reads 0, writes ignored.
- Reset values while rst=0:
  - wbAckO=0, wbDatO=0.
  - OUT=OUT_RESET, DIR=0, EDGE=0, RISE_EN=0, FALL_EN=0, IRQ_EN=0.
  - sync1=sync2=prev=0, primeCnt=0.
  - Hence gpioOut=OUT_RESET, gpioOe=0, irq=0.
- Access handshake:
  - req = wbStbI & wbCycI.
  - Every clock: ack <= req & ~ack. A held request therefore gets ack on alternate cycles, with exactly one idle cycle between back-to-back acks.
  - Latency: ack is high in the cycle after req is first seen.
- Reads: wbDatO is loaded in the same edge that sets ack, from the register selected by wbAdrI. wbDatO holds its value when ack is low.
- Writes:
  - Performed on the edge that sets ack (req & ~ack & wbWeI).
  - Writes to IN and to reserved addresses are ignored but still acked.
  - EDGE write: EDGE <= EDGE & ~wbDatI[WIDTH-1:0].
- Input path:
  - sync1 <= gpioIn; sync2 <= sync1; prev <= sync2.
  - A pin change before edge k is visible in IN after edge k+1.
  - The corresponding EDGE bit sets on edge k+2.
- Edge detection:
  - rise = sync2 & ~prev & RISE_EN; fall = ~sync2 & prev & FALL_EN.
  - Evaluated only when primeCnt == 3.
  - primeCnt is a 2-bit counter that increments from 0 after reset and saturates at 3. Edges are suppressed for the first 3 clocks so reset zeros never produce spurious rising edges.
- EDGE update: EDGE <= (EDGE & ~clearMask) | rise | fall. If a set and a W1C clear hit the same bit on the same edge, the set wins.
- irq = |(EDGE & IRQ_EN), combinational from registers, glitch-free.
- Pin drive: gpioOut = OUT; gpioOe = DIR. Input sampling ignores DIR, so IN reflects the pad (readback of driven pins).
- Reset mid-transaction: ack and wbDatO clear immediately; the pending write is lost; the master re-issues it.
- Request dropped before ack: nothing is performed. A request dropped in the ack cycle completes normally.

Decomposition:
- Shared package: register address constants (ADDR_IN..ADDR_IRQ_EN), the 16-bit data width constant and the sync stage count.
- One natural sub-module: gpio_edge_capture, holding the synchroniser, prev register, prime counter and EDGE W1C logic. It takes sync input, enables and clearMask, and outputs IN and EDGE.
- Bus decode and the other registers stay in the top module.

Test Plan:
- Reset with OUT_RESET=8'h3C, then idle 5 clocks -> gpioOut=3C, gpioOe=00, irq=0, wbAckO=0. Read of addr 1 returns 16'h003C with ack exactly 1 cycle after strobe.
- Write DIR=16'hFF0F, then read addr 2 -> reads 16'h000F (upper bits dropped), gpioOe=8'h0F. Back-to-back held strobe gives the ack pattern 0,1,0,1.
- RISE_EN=01, IRQ_EN=01; gpioIn[0] goes 0->1 before edge k -> IN[0]=1 after k+1, EDGE=01 and irq=1 after k+2. Write EDGE=01 -> EDGE=00, irq=0.
- gpioIn=FF held through reset release with RISE_EN=FF -> EDGE stays 00 (prime suppression). A later FF->00 with FALL_EN=FF gives EDGE=FF.
- Rising edge on bit 1 lands on the same edge as a W1C write of 02 -> EDGE[1]=1 afterwards.
- Assert rst during the ack cycle of a write to OUT -> ack=0 immediately; OUT stays OUT_RESET after release.
